// File: rtl/frame_diff_scanner_if.sv
// ---------------------------------------------------------------------------
// frame_diff_scanner_if
//   Bundles the signals between the raster scanner, the game-state logic and
//   the display command engine.
//   Parameters GRID_W / GRID_H / CODE_W must match the scanner instance.
//   Signals:
//     snake_body, snake_head, apple, border : object flags for the presented x/y
//     game_over, mode_pb                    : restart request (both high)
//     cmd_done                              : display engine ready / draw finished
//     x, y                                  : current cell
//     obj_code, diff                        : draw request for (x, y)
//     init_cycle, en_update, enable_loop,
//     sync_reset                            : frame / state status
//   Modports:
//     master : scanner side (drives x/y and the draw request)
//     slave  : game logic + display engine side
// ---------------------------------------------------------------------------
interface frame_diff_scanner_if #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  logic              snake_body;
  logic              snake_head;
  logic              apple;
  logic              border;
  logic              game_over;
  logic              mode_pb;
  logic              cmd_done;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CODE_W-1:0] obj_code;
  logic              diff;
  logic              init_cycle;
  logic              en_update;
  logic              enable_loop;
  logic              sync_reset;

  modport master (
    input  snake_body, snake_head, apple, border, game_over, mode_pb, cmd_done,
    output x, y, obj_code, diff, init_cycle, en_update, enable_loop, sync_reset
  );

  modport slave (
    output snake_body, snake_head, apple, border, game_over, mode_pb, cmd_done,
    input  x, y, obj_code, diff, init_cycle, en_update, enable_loop, sync_reset
  );
endinterface

// File: rtl/frame_diff_scanner.sv
// ---------------------------------------------------------------------------
// frame_diff_scanner
//   Walks every cell of a GRID_W x GRID_H map, encodes the object flags the
//   game logic presents for the current x/y, compares the code against the
//   last drawn frame and raises a draw request only for changed cells.
//   The first frame after reset/restart redraws every cell.
//   Optional feature: define FDS_FULL_REFRESH_EN to force a full redraw
//   every REFRESH_FRAMES frames.
//   Ports:
//     clk  : system clock, all logic on posedge
//     rst  : synchronous, active-high reset (priority over restart)
//     bus  : frame_diff_scanner_if.master (flags in, cmd_done in,
//            x/y/obj_code/diff and status pulses out)
// ---------------------------------------------------------------------------
module frame_diff_scanner #(
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 12,
  parameter int CODE_W         = 3,
  parameter int REFRESH_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_diff_scanner_if.master bus
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SCAN      = 2'd1;
  localparam logic [1:0] ST_DRAW      = 2'd2;
  localparam logic [1:0] ST_FRAME_END = 2'd3;

  generate
    if (CODE_W < 3 || REFRESH_FRAMES < 1) begin : g_param_check
      $error("frame_diff_scanner: CODE_W must be >= 3 and REFRESH_FRAMES >= 1");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [CODE_W-1:0] r_obj_code;
  logic              r_diff;
  logic              r_init_cycle;
  logic              r_en_update;
  logic              r_sync_reset;
  logic [CODE_W-1:0] r_map [CELLS];

  logic              w_restart;
  logic              w_last_x;
  logic              w_last_y;
  logic              w_frame_done;
  logic [XW-1:0]     w_next_x;
  logic [YW-1:0]     w_next_y;
  logic [IDX_W-1:0]  w_idx;
  logic [2:0]        w_code3;
  logic [CODE_W-1:0] w_ncode;
  logic              w_map_wr;
  logic              w_refresh_due;

  // Flags are combinational responses to the current x/y; head wins overlaps.
  always_comb begin
    w_code3 = 3'd0;
    if (bus.snake_head)      w_code3 = 3'd4;
    else if (bus.snake_body) w_code3 = 3'd3;
    else if (bus.apple)      w_code3 = 3'd2;
    else if (bus.border)     w_code3 = 3'd1;
  end

  assign w_ncode      = CODE_W'(w_code3);
  assign w_idx        = IDX_W'(r_y) * IDX_W'(GRID_W) + IDX_W'(r_x);
  assign w_restart    = bus.game_over & bus.mode_pb;
  assign w_last_x     = (r_x == XW'(GRID_W - 1));
  assign w_last_y     = (r_y == YW'(GRID_H - 1));
  assign w_frame_done = w_last_x & w_last_y;
  assign w_next_x     = w_last_x ? '0 : r_x + 1'b1;
  assign w_next_y     = w_last_x ? (w_last_y ? '0 : r_y + 1'b1) : r_y;
  assign w_map_wr     = (r_state == ST_DRAW) & bus.cmd_done;

`ifdef FDS_FULL_REFRESH_EN
  localparam int CNT_W = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
  logic [CNT_W-1:0] r_frame_cnt;

  assign w_refresh_due = (r_state == ST_FRAME_END) &&
                         (r_frame_cnt == CNT_W'(REFRESH_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_frame_cnt <= '0;
    end else if (r_state == ST_FRAME_END) begin
      r_frame_cnt <= w_refresh_due ? '0 : r_frame_cnt + 1'b1;
    end
  end
`else
  assign w_refresh_due = 1'b0;
`endif

  // Last-drawn frame; cleared so the next full frame starts from a blank map.
  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      for (int i = 0; i < CELLS; i++) r_map[i] <= '0;
    end else if (w_map_wr) begin
      r_map[w_idx] <= r_obj_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_obj_code   <= '0;
      r_diff       <= 1'b0;
      r_init_cycle <= 1'b1;
      r_en_update  <= 1'b0;
      r_sync_reset <= 1'b0;
    end else begin
      r_en_update  <= 1'b0;
      r_sync_reset <= 1'b0;
      if (w_restart) begin
        // Restart aborts whatever is in flight, including a pending draw.
        r_sync_reset <= 1'b1;
        r_x          <= '0;
        r_y          <= '0;
        r_diff       <= 1'b0;
        r_init_cycle <= 1'b1;
        r_state      <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.cmd_done) r_state <= ST_SCAN;
          end
          ST_SCAN: begin
            if (r_init_cycle || (w_ncode != r_map[w_idx])) begin
              r_obj_code <= w_ncode;
              r_diff     <= 1'b1;
              r_state    <= ST_DRAW;
            end else begin
              r_x     <= w_next_x;
              r_y     <= w_next_y;
              r_state <= w_frame_done ? ST_FRAME_END : ST_SCAN;
            end
          end
          ST_DRAW: begin
            if (bus.cmd_done) begin
              r_diff  <= 1'b0;
              r_x     <= w_next_x;
              r_y     <= w_next_y;
              r_state <= w_frame_done ? ST_FRAME_END : ST_SCAN;
            end
          end
          default: begin
            r_en_update  <= 1'b1;
            r_init_cycle <= w_refresh_due;
            r_state      <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.obj_code    = r_obj_code;
  assign bus.diff        = r_diff;
  assign bus.init_cycle  = r_init_cycle;
  assign bus.en_update   = r_en_update;
  assign bus.enable_loop = (r_state == ST_SCAN);
  assign bus.sync_reset  = r_sync_reset;
endmodule
